// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding and index/packing helpers for matmul_seq
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of element [i][j] in a row-major flat vector, element [0][0] in the MSBs.
  function automatic int elem_lsb(input int n, input int w, input int i, input int j);
    return (n * n - 1 - (i * n + j)) * w;
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// rtl/matmul_mac.sv - registered W x W multiply-accumulate with clear and enable
module matmul_mac #(
  parameter int W     = 16,
  parameter int ACC_W = 2 * W + 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic [ACC_W-1:0] sum_o
);

  logic [2*W-1:0]   prod;
  logic [ACC_W-1:0] acc_q;

  assign prod  = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
  // sum_o is the accumulator value including this cycle's product
  assign sum_o = acc_q + {{(ACC_W - 2 * W){1'b0}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

// File: rtl/matmul_seq.sv
// rtl/matmul_seq.sv - sequential NxN unsigned matrix multiplier, one MAC per cycle
module matmul_seq
  import matmul_pkg::*;
#(
  parameter int N   = 3,
  parameter int W   = 16,
  parameter int SAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] a_flat,
  input  logic [N*N*W-1:0] b_flat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] result,
  output logic             overflow
);

  localparam int ACC_W = 2 * W + $clog2(N) + 1;
  localparam int IW    = idx_w(N);
  localparam int NW    = N * N * W;
  localparam int PW    = idx_w(NW);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
  logic [NW-1:0]    a_q, a_d, b_q, b_d, c_q, c_d, res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             mac_clr, mac_en, acc_big;
  logic [PW-1:0]    a_pos, b_pos, c_pos;
  logic [W-1:0]     op_a, op_b, red;
  logic [ACC_W-1:0] acc_sum;

  assign a_pos = PW'(elem_lsb(N, W, int'(i_q), int'(k_q)));
  assign b_pos = PW'(elem_lsb(N, W, int'(k_q), int'(j_q)));
  assign c_pos = PW'(elem_lsb(N, W, int'(i_q), int'(j_q)));
  assign op_a  = a_q[a_pos +: W];
  assign op_b  = b_q[b_pos +: W];

  matmul_mac #(
    .W    (W),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(mac_clr),
    .en_i (mac_en),
    .a_i  (op_a),
    .b_i  (op_b),
    .sum_o(acc_sum)
  );

  assign acc_big = |acc_sum[ACC_W-1:W];
  assign red     = (SAT != 0 && acc_big) ? {W{1'b1}} : acc_sum[W-1:0];

  // in_ready is forced low while reset is asserted, not just in the cycle after
  assign in_ready  = rst_n & (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a_flat;
          b_d     = b_flat;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          ovf_d   = 1'b0;
          mac_clr = 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        mac_en = 1'b1;
        if (k_q == LAST) begin
          c_d[c_pos +: W] = red;
          if (acc_big) ovf_d = 1'b1;
          mac_clr = 1'b1;
          k_d     = '0;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) begin
              res_d   = c_d;
              state_d = ST_DONE;
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            j_d = j_q + IW'(1);
          end
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_matmul_seq.sv
// tb/tb_matmul_seq.sv - self-checking bench for matmul_seq against a behavioural reference
module tb_matmul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         iv3, or3, ir3, ir3s, ov3, ov3s, of3, of3s;
  logic [143:0] a3, b3, r3, r3s;
  logic         iv1, or1, ir1, ov1, of1;
  logic [7:0]   a1, b1, r1;
  logic         iv4, or4, ir4, ov4, of4;
  logic [127:0] a4, b4, r4;

  int n_cmp = 0;
  int n_bad = 0;
  logic [255:0] e3, e3s;
  logic         eo3, eo3s;

  matmul_seq #(.N(3), .W(16), .SAT(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a_flat(a3), .b_flat(b3),
    .out_valid(ov3), .out_ready(or3), .result(r3), .overflow(of3));
  matmul_seq #(.N(3), .W(16), .SAT(1)) u3s (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3s), .a_flat(a3), .b_flat(b3),
    .out_valid(ov3s), .out_ready(or3), .result(r3s), .overflow(of3s));
  matmul_seq #(.N(1), .W(8), .SAT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a_flat(a1), .b_flat(b1),
    .out_valid(ov1), .out_ready(or1), .result(r1), .overflow(of1));
  matmul_seq #(.N(4), .W(8), .SAT(1)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a_flat(a4), .b_flat(b4),
    .out_valid(ov4), .out_ready(or4), .result(r4), .overflow(of4));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind 0: all v, 1: identity, 2: 1..n*n, 3: random in 0..v
  function automatic logic [255:0] mat(input int n, input int w, input int kind, input int v);
    logic [255:0] f;
    longint unsigned e;
    f = '0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        case (kind)
          0:       e = longint'(v);
          1:       e = (i == j) ? 1 : 0;
          2:       e = longint'(i * n + j + 1);
          default: e = longint'($urandom_range(v));
        endcase
        f |= 256'(e) << ((n * n - 1 - (i * n + j)) * w);
      end
    end
    return f;
  endfunction

  function automatic void ref_mm(input int n, input int w, input int sat,
                                 input logic [255:0] af, input logic [255:0] bf,
                                 output logic [255:0] cf, output logic ovf);
    longint unsigned s, mx, x, y;
    mx  = (64'd1 << w) - 64'd1;
    cf  = '0;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) begin
          x = 64'(af >> ((n * n - 1 - (i * n + k)) * w)) & mx;
          y = 64'(bf >> ((n * n - 1 - (k * n + j)) * w)) & mx;
          s += x * y;
        end
        if (s > mx) begin
          ovf = 1'b1;
          s   = (sat != 0) ? mx : (s & mx);
        end
        cf |= 256'(s) << ((n * n - 1 - (i * n + j)) * w);
      end
    end
  endfunction

  function automatic int pick_max();
    case ($urandom_range(2))
      0:       return 3;
      1:       return 15;
      default: return 255;
    endcase
  endfunction

  // Called at a negedge with both N=3 instances idle; returns at the negedge where out_valid is seen.
  task automatic accept3(input logic [255:0] a, input logic [255:0] b, input bit toggle);
    int lat;
    ref_mm(3, 16, 0, a, b, e3, eo3);
    ref_mm(3, 16, 1, a, b, e3s, eo3s);
    chk("in_ready_idle", 256'(ir3), 256'(1));
    a3  = a[143:0];
    b3  = b[143:0];
    iv3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv3 = 1'b0;
    lat = 0;
    while (!ov3 && lat < 200) begin
      if (toggle) begin
        iv3 = 1'($urandom_range(1));
        a3  = a3 ^ 144'($urandom);
      end
      @(negedge clk);
      lat++;
      if (toggle) chk("in_ready_busy", 256'(ir3), 256'(0));
    end
    iv3 = 1'b0;
    chk("latency_n3", 256'(lat), 256'(27));
    chk("out_valid_sat", 256'(ov3s), 256'(1));
    chk("result_wrap", 256'(r3), e3);
    chk("result_sat", 256'(r3s), e3s);
    chk("overflow_wrap", 256'(of3), 256'(eo3));
    chk("overflow_sat", 256'(of3s), 256'(eo3s));
  endtask

  task automatic take3(input int hold, input bit toggle);
    repeat (hold) begin
      @(negedge clk);
      if (toggle) begin
        iv3 = 1'($urandom_range(1));
        a3  = a3 ^ 144'($urandom);
      end
      chk("hold_valid", 256'(ov3), 256'(1));
      chk("hold_result", 256'(r3), e3);
      chk("hold_overflow", 256'(of3), 256'(eo3));
      chk("in_ready_done", 256'(ir3), 256'(0));
    end
    iv3 = 1'b0;
    or3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    or3 = 1'b0;
    chk("valid_drop", 256'(ov3), 256'(0));
    chk("valid_drop_sat", 256'(ov3s), 256'(0));
    chk("in_ready_back", 256'(ir3), 256'(1));
  endtask

  task automatic run1(input int iters);
    logic [255:0] a, b, e;
    logic eo;
    int lat;
    for (int t = 0; t < iters; t++) begin
      a = mat(1, 8, 3, pick_max());
      b = mat(1, 8, 3, pick_max());
      ref_mm(1, 8, 0, a, b, e, eo);
      a1  = a[7:0];
      b1  = b[7:0];
      iv1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv1 = 1'b0;
      lat = 0;
      while (!ov1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("n1_latency", 256'(lat), 256'(1));
      chk("n1_result", 256'(r1), e);
      chk("n1_overflow", 256'(of1), 256'(eo));
      repeat ($urandom_range(2)) @(negedge clk);
      or1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or1 = 1'b0;
    end
  endtask

  task automatic run4(input int iters);
    logic [255:0] a, b, e;
    logic eo;
    int lat;
    for (int t = 0; t < iters; t++) begin
      a = mat(4, 8, 3, pick_max());
      b = mat(4, 8, 3, pick_max());
      ref_mm(4, 8, 1, a, b, e, eo);
      a4  = a[127:0];
      b4  = b[127:0];
      iv4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv4 = 1'b0;
      lat = 0;
      while (!ov4 && lat < 300) begin
        @(negedge clk);
        lat++;
      end
      chk("n4_latency", 256'(lat), 256'(64));
      chk("n4_result", 256'(r4), e);
      chk("n4_overflow", 256'(of4), 256'(eo));
      repeat ($urandom_range(2)) @(negedge clk);
      or4 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      or4 = 1'b0;
    end
  endtask

  initial begin
    logic [255:0] ta, tb;
    rst_n = 1'b0;
    {iv3, or3, iv1, or1, iv4, or4} = '0;
    a3 = '0; b3 = '0; a1 = '0; b1 = '0; a4 = '0; b4 = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 256'(ir3), 256'(0));
    chk("rst_out_valid", 256'(ov3), 256'(0));
    chk("rst_result", 256'(r3), 256'(0));
    chk("rst_overflow", 256'(of3), 256'(0));
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 256'(ir3), 256'(1));
    chk("rel_in_ready_n4", 256'(ir4), 256'(1));
    @(negedge clk);

    accept3(mat(3, 16, 1, 0), mat(3, 16, 2, 0), 1'b0);
    chk("ident_fixed", 256'(r3), 256'(144'h0001_0002_0003_0004_0005_0006_0007_0008_0009));
    take3(0, 1'b0);

    accept3(mat(3, 16, 0, 2), mat(3, 16, 0, 3), 1'b0);
    chk("all18_fixed", 256'(r3), 256'({9{16'd18}}));
    take3(10, 1'b0);

    accept3(mat(3, 16, 0, 'h8000), mat(3, 16, 0, 2), 1'b0);
    chk("wrap_fixed", 256'(r3), 256'(0));
    chk("sat_fixed", 256'(r3s), 256'({9{16'hFFFF}}));
    take3(0, 1'b0);

    ta  = mat(3, 16, 3, 65535);
    tb  = mat(3, 16, 3, 65535);
    a3  = ta[143:0];
    b3  = tb[143:0];
    iv3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv3 = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 256'(ov3), 256'(0));
    chk("midrst_result", 256'(r3), 256'(0));
    chk("midrst_result_sat", 256'(r3s), 256'(0));
    chk("midrst_overflow_sat", 256'(of3s), 256'(0));
    chk("midrst_in_ready", 256'(ir3), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_rel_ready", 256'(ir3), 256'(1));
    accept3(mat(3, 16, 1, 0), mat(3, 16, 0, 5), 1'b0);
    chk("all5_fixed", 256'(r3), 256'({9{16'd5}}));
    take3(0, 1'b0);

    accept3(mat(3, 16, 3, 65535), mat(3, 16, 3, 65535), 1'b1);
    take3(5, 1'b1);
    accept3(mat(3, 16, 3, 255), mat(3, 16, 3, 255), 1'b0);
    take3(0, 1'b0);

    fork
      run1(500);
      run4(500);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
